traffic_request_latch: RTL
==========================

Name: traffic_request_latch

Overview:
- Upstream conditioner for the two-phase traffic light controller.
- Synchronises and debounces raw north-south and east-west call buttons/sensors, and latches each call as a pending request.
- Counts how long each request has waited, and clears a request once the controller shows green to that direction.
- Consumes the controller's nsgreen/ewgreen outputs as the "served" acknowledge.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive clk cycles a synchronised input must differ from its debounced level before that level flips (legal 1..255).
- WAIT_W, 4, width of each wait counter.
- WAIT_MAX, 15, wait counter saturation value (must be at most 2^WAIT_W-1).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- ns_btn  input  1  raw NS call input, asynchronous to clk
- ew_btn  input  1  raw EW call input, asynchronous to clk
- nsgreen  input  1  NS green from controller (served acknowledge)
- ewgreen  input  1  EW green from controller (served acknowledge)
- ns_req  output  1  NS request pending
- ew_req  output  1  EW request pending
- ns_wait  output  WAIT_W  cycles NS request has been pending, saturating
- ew_wait  output  WAIT_W  cycles EW request has been pending, saturating
- ns_urgent  output  1  ns_wait == WAIT_MAX
- ew_urgent  output  1  ew_wait == WAIT_MAX

Behaviour:
- **Reset.** One clock; reset is asynchronous and active-high on rst. It clears immediately:
  - all outputs;
  - both 2-flop synchronisers;
  - the debounced levels and debounce counters;
  - the wait counters.
- **Synchronise.** Each button passes through 2 flops (s1, s2).
- **Debounce, per channel.**
  - If s2 equals the debounced level, the counter is set to 0.
  - Otherwise the counter increments.
  - When the counter is at DEBOUNCE_CYCLES-1 and s2 still differs, the debounced level takes s2 and the counter returns to 0.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never changes the debounced level.
- **Press event.** A press is a rising edge of the debounced level, one cycle wide and internal only. Release (falling edge) has no effect on requests.
- **Request latch, per direction, evaluated at each edge in priority order:**
  1. If own green=1: req<=0 and wait<=0. Clear dominates, so a press arriving while that direction is green is discarded.
  2. Else if press: req<=1 and wait<=0.
  3. Else if req=1: wait<=wait+1, saturating at WAIT_MAX.
- **Repeat presses.** A repeated press while req=1 restarts nothing: wait keeps counting.
- **Latency.** Count the first edge that samples btn high as edge 1.
  - req rises on edge DEBOUNCE_CYCLES+3.
  - wait reads 1 one edge after that.
- **Service latency.** req and wait clear on the first edge at which own green is sampled high.
- **Urgent flags.** ns_urgent and ew_urgent are combinational compares of the registered wait values.
- **Channel independence.** NS and EW are fully independent. Simultaneous presses latch both requests on the same edge.
- **Reset mid-operation.** A button held high through reset deasserts the synchronisers. After rst falls it is treated as a new press: req rises DEBOUNCE_CYCLES+3 edges later, unless own green is high.
- **Both greens high.** Both requests clear and both wait counters are held at 0 while the condition persists.

Optional Feature:
- Macro: TRAFFIC_CONFLICT_DET_EN.
- **With the macro:**
  - Extra output port conflict (1 bit), reset 0.
  - conflict is set on any edge where nsgreen and ewgreen are both sampled high.
  - It is sticky; only rst clears it.
- **Without the macro:** the port is absent and no conflict logic is built. All other behaviour is identical.

Decomposition:
- **Shared package traffic_pkg:**
  - DEBOUNCE_CYCLES_DEF and WAIT_MAX_DEF constants.
  - Direction index constants DIR_NS=0, DIR_EW=1.
- **Sub-module btn_conditioner:** the natural split, instantiated twice. It contains the 2-flop synchroniser, the debounce counter and the press pulse generator.
  - Ports: clk, rst, btn_raw, press.
  - Parameter: DEBOUNCE_CYCLES.
- **Top level:** request latches, wait counters and the optional conflict flag.

Test Plan:
- **Clean press.** DEBOUNCE_CYCLES=4; ns_btn held high from edge 1, both greens 0 -> ns_req=0 through edge 6, ns_req=1 at edge 7, ns_wait=1 at edge 8. ew_req stays 0.
- **Glitch rejection.** ew_btn high for 3 synchronised cycles, then low -> ew_req never asserts, ew_wait stays 0.
- **Saturation and service.** ns_req pending, nsgreen=0 for 30 cycles -> ns_wait stops at 15 and ns_urgent=1. Then nsgreen=1 for one edge -> ns_req=0, ns_wait=0 and ns_urgent=0 on that edge.
- **Press during green.** ewgreen=1 while an ew_btn press matures -> ew_req stays 0. A second press after ewgreen drops -> ew_req=1 DEBOUNCE_CYCLES+3 edges later.
- **Reset mid-operation.** Both reqs pending with wait=9; pulse rst asynchronously between edges -> all outputs 0 immediately. With ns_btn still held, ns_req reasserts 7 edges after rst falls.
- **Conflict (TRAFFIC_CONFLICT_DET_EN defined).** nsgreen=ewgreen=1 for one edge -> conflict=1, both reqs cleared. conflict stays 1 after the greens fall, until rst.

Source files
------------

// File: rtl/traffic_request_latch_pkg.sv
// Shared constants for the traffic request conditioner slice.
// Defaults for the debounce length and wait-counter limits, plus the
// direction indices used to address the per-direction vectors.
package traffic_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
  localparam int unsigned WAIT_W_DEF          = 4;
  localparam int unsigned WAIT_MAX_DEF        = 15;

  localparam int unsigned DIR_NS = 0;
  localparam int unsigned DIR_EW = 1;

endpackage

// File: rtl/traffic_request_latch_btn_conditioner.sv
// btn_conditioner: 2-flop synchroniser, counter debounce and a one-cycle
// press pulse on each rising edge of the debounced level.
// The debounced level flips only after DEBOUNCE_CYCLES consecutive
// synchronised samples that disagree with it.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       s1;
  logic       s2;
  logic       level;
  logic       level_d;
  logic [7:0] cnt;

  // Two-stage synchroniser for the asynchronous raw input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // Debounce: count consecutive disagreeing samples, flip level on the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (s2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      level <= s2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  // Delayed copy of the debounced level for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_d <= 1'b0;
    end else begin
      level_d <= level;
    end
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/traffic_request_latch.sv
// traffic_request_latch: conditions NS/EW call inputs, latches pending
// requests, counts how long each has waited and clears a request when the
// controller shows green to that direction.
// Optional build macro TRAFFIC_CONFLICT_DET_EN adds a sticky 'conflict'
// output flagging any edge where both greens were seen together.
module traffic_request_latch
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned WAIT_W          = WAIT_W_DEF,
  parameter int unsigned WAIT_MAX        = WAIT_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ns_btn,
  input  logic              ew_btn,
  input  logic              nsgreen,
  input  logic              ewgreen,
  output logic              ns_req,
  output logic              ew_req,
  output logic [WAIT_W-1:0] ns_wait,
  output logic [WAIT_W-1:0] ew_wait,
  output logic              ns_urgent,
  output logic              ew_urgent
`ifdef TRAFFIC_CONFLICT_DET_EN
  ,
  output logic              conflict
`endif
);

  localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_MAX[WAIT_W-1:0];

  logic [1:0]             btn_raw;
  logic [1:0]             green;
  logic [1:0]             press;
  logic [1:0]             req_q;
  logic [1:0][WAIT_W-1:0] wait_q;

  assign btn_raw[DIR_NS] = ns_btn;
  assign btn_raw[DIR_EW] = ew_btn;
  assign green[DIR_NS]   = nsgreen;
  assign green[DIR_EW]   = ewgreen;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ns_cond (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_raw[DIR_NS]),
    .press  (press[DIR_NS])
  );

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ew_cond (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_raw[DIR_EW]),
    .press  (press[DIR_EW])
  );

  for (genvar d = 0; d < 2; d++) begin : g_dir
    // Request latch and wait counter: own green clears, press sets, else age.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        req_q[d]  <= 1'b0;
        wait_q[d] <= '0;
      end else if (green[d]) begin
        req_q[d]  <= 1'b0;
        wait_q[d] <= '0;
      end else if (press[d] && !req_q[d]) begin
        req_q[d]  <= 1'b1;
        wait_q[d] <= '0;
      end else if (req_q[d]) begin
        if (wait_q[d] != WAIT_SAT) begin
          wait_q[d] <= wait_q[d] + WAIT_W'(1);
        end
      end
    end
  end

  assign ns_req    = req_q[DIR_NS];
  assign ew_req    = req_q[DIR_EW];
  assign ns_wait   = wait_q[DIR_NS];
  assign ew_wait   = wait_q[DIR_EW];
  assign ns_urgent = (wait_q[DIR_NS] == WAIT_SAT);
  assign ew_urgent = (wait_q[DIR_EW] == WAIT_SAT);

`ifdef TRAFFIC_CONFLICT_DET_EN
  // Sticky record of any edge that sampled both greens high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict <= 1'b0;
    end else if (nsgreen && ewgreen) begin
      conflict <= 1'b1;
    end
  end
`endif

endmodule
